console_host: RTL
=================

Name: console_host

Overview:
- Bus initiator (host) side of the simulation console.
- Accepts characters on a valid/ready stream and buffers them in a FIFO.
- Drains the FIFO as single-beat writes to the console's CHAR_OUT register over the simple Ibex-style request/grant/rvalid bus.
- On request, ends simulation by writing 1 to the console's SIM_CTRL register. Used by testbench traffic generators and non-CPU masters that need console output without firmware.

Parameters:
- BASE_ADDR, 32'h0002_0000, console base address; CHAR_OUT = BASE_ADDR+0x0, SIM_CTRL = BASE_ADDR+0x8.
- FIFO_DEPTH, 8, character buffer entries; power of two, >=2.
- TIMEOUT, 15, cycles to wait for rvalid_i after grant before abandoning a transfer; >=1.

Ports:
- ck_i  in  1  clock, all logic on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- char_valid_i  in  1  character available.
- char_i  in  8  character byte.
- char_ready_o  out  1  character accepted when char_valid_i & char_ready_o.
- finish_i  in  1  single-cycle pulse: terminate simulation once the FIFO is drained.
- busy_o  out  1  FIFO non-empty or transfer in flight or finish pending.
- req_o  out  1  bus request.
- gnt_i  in  1  bus grant.
- we_o  out  1  write enable; always 1 while req_o.
- be_o  out  4  byte enables; 4'b0001 while req_o.
- addr_o  out  32  word address.
- wd_o  out  32  write data; {24'b0, byte} for CHAR_OUT, 32'h1 for SIM_CTRL.
- rvalid_i  in  1  responder completion.
- err_o  out  1  sticky timeout flag.
- sent_cnt_o  out  16  completed CHAR_OUT writes; wraps 16'hFFFF->0.

Behaviour:
- Reset: all outputs 0 except char_ready_o, which is 0 during reset and 1 the first cycle after reset release. FIFO empty, state IDLE, finish_pend 0, counters 0.
- Reset mid-transaction aborts the transfer and flushes the FIFO; there is no bus retry.
- FIFO: push on char_valid_i & char_ready_o.
  - char_ready_o = !full & !finish_pend & state!=DONE.
  - At full, no push, even in a cycle that pops.
  - Head entry is popped only when its transfer completes (rvalid_i or timeout).
- finish_i sets finish_pend. Pulses while pending or in DONE are ignored.
- FSM:
  - IDLE: if FIFO non-empty, go to REQ with a CHAR_OUT access. Else if finish_pend, go to REQ with a SIM_CTRL access. Char data has priority over finish.
  - REQ: req_o=1; addr/wd/be/we held stable. On gnt_i, drop req_o next cycle and go to WAIT. Request held indefinitely without grant; no timeout in REQ.
  - WAIT: wait counter increments each cycle.
    - rvalid_i before timeout: CHAR access pops the FIFO, increments sent_cnt_o, and returns to IDLE. SIM_CTRL access goes to DONE.
    - Counter reaches TIMEOUT: set err_o, pop/discard as if completed, go to IDLE. A SIM_CTRL timeout also goes to DONE.
  - DONE: terminal until reset; req_o=0, char_ready_o=0.
- rvalid_i outside WAIT is ignored.
- rvalid_i in the same cycle as gnt_i is not counted; the responder replies the cycle after grant.
- Throughput: one character per 3 cycles (IDLE, REQ+gnt, WAIT+rvalid) with immediate grant and response.
- busy_o = !empty | state in {REQ, WAIT} | finish_pend, excluding DONE.

Optional Feature:
- CONSOLE_HOST_CRLF_EN defined: a CHAR_OUT of 8'h0A is preceded by a separate write of 8'h0D.
  - Two full bus transactions; the FIFO pops only after the 0x0A completes.
  - sent_cnt_o counts both writes.
  - A timeout on the 0x0D still sends the 0x0A.
- Undefined: bytes pass unchanged; one write per FIFO entry.

Test Plan:
- Push "Hi" (0x48, 0x69) with gnt_i=1 and responder replying next cycle -> two writes to addr 32'h0002_0000, wd 0x48 then 0x69, be 4'b0001, sent_cnt_o=2, busy_o falls.
- Push 9 bytes back-to-back with gnt_i=0 -> char_ready_o low after 8 accepted. Raise gnt_i -> all 8 sent in order, ready returns.
- Push 3 bytes, then pulse finish_i -> 3 CHAR_OUT writes, then one write to 32'h0002_0008 with wd 32'h1. DONE reached, char_ready_o=0 and stays 0.
- Grant with no rvalid_i -> err_o=1 exactly 15 cycles after grant. Byte dropped, next byte proceeds, err_o stays set.
- Assert rst_ni low during WAIT with 4 bytes queued -> outputs 0 immediately. After release the FIFO is empty and no request is issued.
- With CONSOLE_HOST_CRLF_EN, push 0x0A -> writes 0x0D then 0x0A, sent_cnt_o=2. Without the macro -> single write of 0x0A.

Source files
------------

// File: rtl/console_host.sv
// console_host: bus-initiator side of the simulation console.
// Characters arrive on a valid/ready stream and are buffered in a FIFO.
// Each buffered byte is written to CHAR_OUT as a single request/grant/rvalid
// bus transfer. A finish request ends the session with a write of 1 to
// SIM_CTRL once the FIFO has drained.
// Build option: define CONSOLE_HOST_CRLF_EN to send a 0x0D write ahead of
// every 0x0A byte.
module console_host #(
  parameter logic [31:0] BASE_ADDR  = 32'h0002_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          TIMEOUT    = 15
) (
  input  logic        ck_i,
  input  logic        rst_ni,
  input  logic        char_valid_i,
  input  logic [7:0]  char_i,
  output logic        char_ready_o,
  input  logic        finish_i,
  output logic        busy_o,
  output logic        req_o,
  input  logic        gnt_i,
  output logic        we_o,
  output logic [3:0]  be_o,
  output logic [31:0] addr_o,
  output logic [31:0] wd_o,
  input  logic        rvalid_i,
  output logic        err_o,
  output logic [15:0] sent_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   PTR_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT);

  localparam logic [31:0] CHAR_OUT_ADDR = BASE_ADDR;
  localparam logic [31:0] SIM_CTRL_ADDR = BASE_ADDR + 32'h8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          finish_pend_q, finish_pend_d;
  logic          live_q;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wd_q, wd_d;
  logic          acc_sim_q, acc_sim_d;
  logic          acc_cr_q, acc_cr_d;
  logic          cr_done_q, cr_done_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          err_q, err_d;
  logic [15:0]   sent_cnt_q, sent_cnt_d;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [7:0]    head_byte;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          need_cr;
  logic          xfer_done;
  logic          xfer_ok;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = ((wr_ptr_q - rd_ptr_q) == PTR_FULL);
  assign head_byte  = fifo_mem[rd_ptr_q[AW-1:0]];

  // live_q holds ready low until the first clock after reset release.
  assign char_ready_o = live_q & ~fifo_full & ~finish_pend_q & (state_q != S_DONE);
  assign push         = char_valid_i & char_ready_o;

`ifdef CONSOLE_HOST_CRLF_EN
  // A line feed at the head needs its carriage return sent first.
  assign need_cr = (head_byte == 8'h0A) & ~cr_done_q;
`else
  assign need_cr = 1'b0;
`endif

  assign busy_o     = (state_q != S_DONE) &
                      (~fifo_empty | (state_q == S_REQ) | (state_q == S_WAIT) | finish_pend_q);
  assign req_o      = req_q;
  assign we_o       = we_q;
  assign be_o       = be_q;
  assign addr_o     = addr_q;
  assign wd_o       = wd_q;
  assign err_o      = err_q;
  assign sent_cnt_o = sent_cnt_q;

  // Character storage; written on accept, read through the head pointer.
  always_ff @(posedge ck_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= char_i;
    end
  end

  // Next-state logic for the FIFO pointers, finish request and bus FSM.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    finish_pend_d = finish_pend_q;
    req_d         = req_q;
    we_d          = we_q;
    be_d          = be_q;
    addr_d        = addr_q;
    wd_d          = wd_q;
    acc_sim_d     = acc_sim_q;
    acc_cr_d      = acc_cr_q;
    cr_done_d     = cr_done_q;
    wait_cnt_d    = wait_cnt_q;
    err_d         = err_q;
    sent_cnt_d    = sent_cnt_q;
    xfer_done     = 1'b0;
    xfer_ok       = 1'b0;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    // Repeated finish pulses while one is pending (or after DONE) are dropped.
    if (finish_i && !finish_pend_q && (state_q != S_DONE)) begin
      finish_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        // Buffered characters always go out before the finish write.
        if (!fifo_empty) begin
          state_d   = S_REQ;
          req_d     = 1'b1;
          we_d      = 1'b1;
          be_d      = 4'b0001;
          addr_d    = CHAR_OUT_ADDR;
          acc_sim_d = 1'b0;
          if (need_cr) begin
            wd_d     = 32'h0000_000D;
            acc_cr_d = 1'b1;
          end else begin
            wd_d     = {24'b0, head_byte};
            acc_cr_d = 1'b0;
          end
        end else if (finish_pend_q) begin
          state_d   = S_REQ;
          req_d     = 1'b1;
          we_d      = 1'b1;
          be_d      = 4'b0001;
          addr_d    = SIM_CTRL_ADDR;
          wd_d      = 32'h0000_0001;
          acc_sim_d = 1'b1;
          acc_cr_d  = 1'b0;
        end
      end

      S_REQ: begin
        // The request is held for as long as the responder withholds grant.
        if (gnt_i) begin
          state_d    = S_WAIT;
          req_d      = 1'b0;
          we_d       = 1'b0;
          be_d       = 4'b0000;
          wait_cnt_d = '0;
        end
      end

      S_WAIT: begin
        if (rvalid_i) begin
          xfer_done = 1'b1;
          xfer_ok   = 1'b1;
        end else if ((wait_cnt_q + CNT_ONE) == CNT_LAST) begin
          xfer_done = 1'b1;
          err_d     = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_ONE;
        end

        // A timed-out transfer is retired exactly like a completed one.
        if (xfer_done) begin
          if (acc_sim_q) begin
            state_d       = S_DONE;
            finish_pend_d = 1'b0;
          end else begin
            state_d = S_IDLE;
            if (xfer_ok) begin
              sent_cnt_d = sent_cnt_q + 16'd1;
            end
            if (acc_cr_q) begin
              cr_done_d = 1'b1;
            end else begin
              rd_ptr_d  = rd_ptr_q + PTR_ONE;
              cr_done_d = 1'b0;
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_DONE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset aborts any transfer and empties the FIFO.
  always_ff @(posedge ck_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      finish_pend_q <= 1'b0;
      live_q        <= 1'b0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      be_q          <= 4'b0000;
      addr_q        <= '0;
      wd_q          <= '0;
      acc_sim_q     <= 1'b0;
      acc_cr_q      <= 1'b0;
      cr_done_q     <= 1'b0;
      wait_cnt_q    <= '0;
      err_q         <= 1'b0;
      sent_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      finish_pend_q <= finish_pend_d;
      live_q        <= 1'b1;
      req_q         <= req_d;
      we_q          <= we_d;
      be_q          <= be_d;
      addr_q        <= addr_d;
      wd_q          <= wd_d;
      acc_sim_q     <= acc_sim_d;
      acc_cr_q      <= acc_cr_d;
      cr_done_q     <= cr_done_d;
      wait_cnt_q    <= wait_cnt_d;
      err_q         <= err_d;
      sent_cnt_q    <= sent_cnt_d;
    end
  end

endmodule
